// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - control, address handshake and decode output bundle for decoder_seq
interface decoder_seq_if #(
    parameter int ADDR_W = 4
);
    localparam int OUT_W = 2 ** ADDR_W;

    logic              enable;
    logic              mode;
    logic              in_valid;
    logic [ADDR_W-1:0] in;
    logic              in_ready;
    logic [OUT_W-1:0]  out;
    logic [ADDR_W-1:0] cur_addr;
    logic              wrap;

    modport master (
        output enable, mode, in_valid, in,
        input  in_ready, out, cur_addr, wrap
    );

    modport slave (
        input  enable, mode, in_valid, in,
        output in_ready, out, cur_addr, wrap
    );
endinterface

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - one-hot decoder with direct-address hold and timed scan modes; optional wrap pulse via DECODER_SEQ_WRAP_EN
module decoder_seq #(
    parameter int ADDR_W = 4,
    parameter int PERIOD = 4
) (
    input logic          clk,
    input logic          rst,
    decoder_seq_if.slave bus
);
    localparam int OUT_W = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0] STEP_MAX = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              in_ready_w;

    // Acceptance depends only on the live controls, never on state or reset.
    assign in_ready_w   = bus.enable && !bus.mode;
    assign bus.in_ready = in_ready_w;
    assign bus.out      = out_q;
    assign bus.cur_addr = addr_q;

`ifdef DECODER_SEQ_WRAP_EN
    logic wrap_q, wrap_d;
    assign bus.wrap = wrap_q;
`else
    assign bus.wrap = 1'b0;
`endif

    // Next state, address and step count; priority is !enable > mode > in_valid.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
`ifdef DECODER_SEQ_WRAP_EN
        wrap_d  = 1'b0;
`endif
        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bus.mode) begin
            if (state_q != SCAN) begin
                // Every scan starts from address 0 with a fresh step count.
                state_d = SCAN;
                addr_d  = '0;
                cnt_d   = '0;
            end else if (cnt_q == STEP_MAX) begin
                cnt_d  = '0;
                addr_d = addr_q + 1'b1;
`ifdef DECODER_SEQ_WRAP_EN
                wrap_d = (addr_q == '1);
`endif
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
            if (bus.in_valid) begin
                state_d = HOLD;
                addr_d  = bus.in;
            end else if (state_q == SCAN) begin
                // Leaving scan freezes on whatever address was being driven.
                state_d = HOLD;
            end
        end
    end

    // Decode is computed from next-state values so out lines up with cur_addr.
    always_comb begin
        out_d = '0;
        if (state_d != IDLE) begin
            out_d = OUT_W'(1) << addr_d;
        end
    end

    // State, address, step counter and registered decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

`ifdef DECODER_SEQ_WRAP_EN
    // One-cycle wrap flag, aligned with the first cycle out shows address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end
`endif
endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - directed self-checking bench for decoder_seq
module tb_decoder_seq;
    logic clk = 1'b0;
    logic rst;
    logic rst1;
    int   tests = 0;
    int   fails = 0;

`ifdef DECODER_SEQ_WRAP_EN
    localparam logic [31:0] WRAP_EXP = 32'd1;
`else
    localparam logic [31:0] WRAP_EXP = 32'd0;
`endif

    always #5 clk = ~clk;

    decoder_seq_if #(.ADDR_W(4)) b0 ();
    decoder_seq_if #(.ADDR_W(2)) b1 ();

    decoder_seq #(.ADDR_W(4), .PERIOD(2)) dut0 (.clk(clk), .rst(rst),  .bus(b0.slave));
    decoder_seq #(.ADDR_W(2), .PERIOD(1)) dut1 (.clk(clk), .rst(rst1), .bus(b1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst1 = 1'b1;
        b0.enable = 1'b0; b0.mode = 1'b0; b0.in_valid = 1'b0; b0.in = 4'd0;
        b1.enable = 1'b0; b1.mode = 1'b0; b1.in_valid = 1'b0; b1.in = 2'd0;
        step();
        chk("rst_out",      32'(b0.out),      32'h0);
        chk("rst_cur_addr", 32'(b0.cur_addr), 32'd0);
        chk("rst_wrap",     32'(b0.wrap),     32'd0);
        chk("rst_in_ready", 32'(b0.in_ready), 32'd0);
        b0.enable = 1'b1;
        #1;
        chk("in_ready_during_rst", 32'(b0.in_ready), 32'd1);
        b0.enable = 1'b0;
        rst = 1'b0; rst1 = 1'b0;
        step();
        chk("idle_out", 32'(b0.out), 32'h0);

        // direct decode
        b0.enable = 1'b1; b0.mode = 1'b0; b0.in_valid = 1'b1; b0.in = 4'd9;
        #1;
        chk("direct_in_ready", 32'(b0.in_ready), 32'd1);
        step();
        chk("direct9_out",  32'(b0.out),      32'h0200);
        chk("direct9_addr", 32'(b0.cur_addr), 32'd9);
        b0.in = 4'd0;
        step();
        chk("direct0_out", 32'(b0.out), 32'h0001);
        b0.in_valid = 1'b0; b0.in = 4'd6;
        step();
        chk("hold_stable_out", 32'(b0.out), 32'h0001);

        // scan: k counts cycles since the entering edge
        b0.mode = 1'b1;
        step();
        chk("scan_enter_out",  32'(b0.out),      32'h0001);
        chk("scan_enter_addr", 32'(b0.cur_addr), 32'd0);
        chk("scan_enter_wrap", 32'(b0.wrap),     32'd0);
        for (int k = 1; k <= 42; k++) begin
            step();
            chk("scan_out",  32'(b0.out),  32'(1) << ((k / 2) % 16));
            chk("scan_wrap", 32'(b0.wrap), (k == 32) ? WRAP_EXP : 32'd0);
        end
        chk("scan_at5_addr", 32'(b0.cur_addr), 32'd5);

        // drop mode: freeze at 5
        b0.mode = 1'b0;
        step();
        chk("hold5_out",  32'(b0.out),      32'h0020);
        chk("hold5_addr", 32'(b0.cur_addr), 32'd5);
        step();
        chk("hold5_stable", 32'(b0.out), 32'h0020);

        // valid with mode high is ignored; mode re-enters scan from 0
        b0.mode = 1'b1; b0.in_valid = 1'b1; b0.in = 4'd3;
        #1;
        chk("mode_in_ready", 32'(b0.in_ready), 32'd0);
        step();
        chk("mode_ignore_addr", 32'(b0.cur_addr), 32'd0);
        chk("mode_ignore_out",  32'(b0.out),      32'h0001);

        // enable priority
        b0.mode = 1'b0; b0.in_valid = 1'b1; b0.in = 4'd7;
        step();
        chk("hold7_out", 32'(b0.out), 32'h0080);
        b0.enable = 1'b0; b0.in = 4'd2;
        #1;
        chk("dis_in_ready", 32'(b0.in_ready), 32'd0);
        step();
        chk("dis_out",  32'(b0.out),      32'h0);
        chk("dis_addr", 32'(b0.cur_addr), 32'd7);
        b0.enable = 1'b1; b0.in_valid = 1'b0;
        step();
        chk("reen_idle_out", 32'(b0.out), 32'h0);
        step();
        chk("reen_idle_out2", 32'(b0.out), 32'h0);
        chk("reen_idle_addr", 32'(b0.cur_addr), 32'd7);

        // PERIOD=1, ADDR_W=2: step every cycle, wrap, then reset mid-scan
        b1.enable = 1'b1; b1.mode = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("p1_out",  32'(b1.out),      32'(1) << (k % 4));
            chk("p1_addr", 32'(b1.cur_addr), 32'(k % 4));
            chk("p1_wrap", 32'(b1.wrap),     (k == 4) ? WRAP_EXP : 32'd0);
        end
        rst1 = 1'b1;
        step();
        chk("p1_rst_out",  32'(b1.out),      32'h0);
        chk("p1_rst_wrap", 32'(b1.wrap),     32'd0);
        chk("p1_rst_addr", 32'(b1.cur_addr), 32'd0);
        rst1 = 1'b0;
        step();
        chk("p1_rescan_out", 32'(b1.out), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 Parameter: ADDR_W, default 4, address width; legal range 1..8.
REQ-002 Parameter: PERIOD, default 4, cycles each output stays selected in scan mode; legal range 1..65535.
REQ-003 Derived width: OUT_W = 2**ADDR_W, computed internally and not overridable.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 Port: clk  input  1  rising-edge clock for all state.
REQ-006 Port: rst  input  1  synchronous active-high reset.
REQ-007 Port: enable  input  1  block enable; low forces all outputs to zero.
REQ-008 Port: mode  input  1  mode select: 0 = direct (addressed), 1 = scan (auto-step).
REQ-009 Port: in_valid  input  1  address offer qualifier.
REQ-010 Port: in  input  ADDR_W  address to decode.
REQ-011 Port: in_ready  output  1  address acceptance; combinational, equals enable && !mode.
REQ-012 Port: out  output  OUT_W  registered one-hot decode, or all zero.
REQ-013 Port: cur_addr  output  ADDR_W  registered currently selected address.
REQ-014 Port: wrap  output  1  single-cycle pulse when scan wraps from the top address to 0.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, HOLD, SCAN.
REQ-016 out SHALL equal one-hot(cur_addr) in HOLD and SCAN, and all zero in IDLE, with never more than one bit set.
REQ-017 Address acceptance SHALL occur on a clock edge where in_valid && in_ready is high.
REQ-018 On acceptance, cur_addr SHALL load in and the state SHALL become HOLD, with the effect visible on out one cycle after that edge.
REQ-019 IDLE SHALL move to HOLD on acceptance, and to SCAN when enable && mode is high.
REQ-020 HOLD SHALL keep out stable, and each new acceptance SHALL update cur_addr, with back-to-back accepts allowed every cycle.
REQ-021 HOLD SHALL move to SCAN when enable && mode is high.
REQ-022 Entering SCAN from either state SHALL set cur_addr to 0 and clear the step counter.
REQ-023 In SCAN, cur_addr SHALL increment every PERIOD cycles, so each address is driven for exactly PERIOD cycles.
REQ-024 In SCAN, cur_addr SHALL wrap from OUT_W-1 to 0, and the cycle-by-cycle step sequence SHALL be 0,1,...,OUT_W-1,0.
REQ-025 SCAN with enable && !mode SHALL move to HOLD, keeping the current cur_addr, and the step counter SHALL be cleared.
REQ-026 In any state, enable low on an edge SHALL make the next state IDLE, out zero, and the step counter cleared; cur_addr SHALL retain its value.
REQ-027 Priority SHALL be rst > !enable > mode > in_valid, and in_valid with mode high SHALL be ignored.
REQ-028 When PERIOD = 1, cur_addr SHALL step every cycle.
REQ-029 The step counter SHALL be ceil(log2(PERIOD+1)) bits wide and SHALL never exceed PERIOD-1.

Reset
REQ-030 On rst high at a clock edge: state = IDLE, out = 0, cur_addr = 0, wrap = 0, step counter = 0.
REQ-031 rst asserted mid-scan SHALL abort the scan with no wrap pulse, and out SHALL be zero on the cycle after the reset edge.
REQ-032 in_ready SHALL follow its combinational definition regardless of reset state.

Configuration
REQ-033 Macro DECODER_SEQ_WRAP_EN defined: wrap SHALL be registered high for exactly one cycle, coincident with the first cycle out shows address 0 after a wrap.
REQ-034 Entering SCAN SHALL NOT pulse wrap.
REQ-035 Macro DECODER_SEQ_WRAP_EN undefined: wrap SHALL be tied constant 0, with no wrap logic synthesised; the port SHALL remain present.

Verification (ADDR_W=4, PERIOD=2 unless stated)
REQ-036 Reset then idle: rst 1 cycle, enable=0 -> out=16'h0000, cur_addr=0, wrap=0, in_ready=0.
REQ-037 Direct decode: enable=1, mode=0, in_valid=1, in=4'd9 on edge N -> out=16'h0200 from edge N+1; in=4'd0 next cycle -> out=16'h0001.
REQ-038 Scan sequence and wrap: enable=1, mode=1 for 40 cycles -> out steps 16'h0001, 16'h0002, ..., 16'h8000, each for 2 cycles; then returns to 16'h0001 with wrap=1 for one cycle (macro on) or wrap=0 throughout (macro off).
REQ-039 Mode switch and ignore: in scan at cur_addr=5, drop mode -> out holds 16'h0020 in HOLD; in_valid=1, in=4'd3 while mode=1 -> no change, in_ready=0.
REQ-040 Enable priority: in HOLD at address 7, enable=0 with in_valid=1, in=4'd2 -> out=0 next cycle, cur_addr stays 7; re-enable with mode=0 and no valid -> remains IDLE, out=0.
REQ-041 Reset mid-scan with PERIOD=1, ADDR_W=2: rst at cur_addr=3 -> next cycle out=4'b0000, wrap=0, cur_addr=0.
